// File: rtl/hdmi_cfg_sequencer.sv
// Boot-time / on-demand HDMI transmitter configuration sequencer: walks a fixed
// register table through the I2C byte-write master with retry and timeout handling.
module hdmi_cfg_sequencer #(
  parameter int         POWERUP_CYCLES = 2500000,
  parameter int         TIMEOUT_CYCLES = 250000,
  parameter int         RETRY_GAP      = 25000,
  parameter int         MAX_RETRIES    = 3,
  parameter logic [6:0] DEV_ADDR       = 7'h39
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_restart,
  input  logic       i_done,
  input  logic       i_nack,
  output logic       o_req,
  output logic [6:0] o_dev_addr,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_data,
  output logic [3:0] o_index,
  output logic       o_config_ok,
  output logic       o_config_fail
);

  localparam int MAX_TP  = (TIMEOUT_CYCLES > RETRY_GAP) ? TIMEOUT_CYCLES : RETRY_GAP;
  localparam int MAX_CNT = (POWERUP_CYCLES > MAX_TP) ? POWERUP_CYCLES : MAX_TP;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;
  localparam int RTY_W   = $clog2(MAX_RETRIES) + 1;

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RETRY_GAP - 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_ISSUE, S_WAIT, S_GAP, S_NEXT, S_DONE, S_FAIL
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [RTY_W-1:0] retries;
  logic             restart_pend;
  logic             wait_exit;
  logic             do_restart;

  // {register, data} for each table entry
  function automatic logic [15:0] cfg_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    cfg_entry = 16'h4110;
      4'd1:    cfg_entry = 16'h9803;
      4'd2:    cfg_entry = 16'h9AE0;
      4'd3:    cfg_entry = 16'h9C30;
      4'd4:    cfg_entry = 16'h9D61;
      4'd5:    cfg_entry = 16'hA2A4;
      4'd6:    cfg_entry = 16'hA3A4;
      4'd7:    cfg_entry = 16'hE0D0;
      4'd8:    cfg_entry = 16'hF900;
      4'd9:    cfg_entry = 16'h1501;
      default: cfg_entry = 16'h4110;
    endcase
  endfunction

  assign o_dev_addr = DEV_ADDR;

  // A restart seen during WAIT is deferred until the transfer completes or times out.
  assign wait_exit  = (state == S_WAIT) && (i_done || (cnt == TMO_LAST));
  assign do_restart = (state == S_WAIT) ? (wait_exit && (restart_pend || i_restart))
                                        : i_restart;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_PWRUP;
      cnt           <= '0;
      retries       <= '0;
      restart_pend  <= 1'b0;
      o_req         <= 1'b0;
      o_index       <= 4'd0;
      o_config_ok   <= 1'b0;
      o_config_fail <= 1'b0;
      o_reg_addr    <= 8'h41;
      o_reg_data    <= 8'h10;
    end else if (do_restart) begin
      state         <= S_ISSUE;
      cnt           <= '0;
      retries       <= '0;
      restart_pend  <= 1'b0;
      o_req         <= 1'b0;
      o_index       <= 4'd0;
      o_config_ok   <= 1'b0;
      o_config_fail <= 1'b0;
    end else begin
      case (state)
        S_PWRUP: begin
          if (cnt == PWR_LAST) begin
            state <= S_ISSUE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_ISSUE: begin
          o_req                    <= 1'b1;
          cnt                      <= '0;
          {o_reg_addr, o_reg_data} <= cfg_entry(o_index);
          state                    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_exit) begin
            o_req <= 1'b0;
            cnt   <= '0;
            if (i_done && !i_nack)
              state <= S_NEXT;
            else if (retries < RTY_W'(MAX_RETRIES))
              state <= S_GAP;
            else
              state <= S_FAIL;
          end else begin
            cnt          <= cnt + CNT_W'(1);
            restart_pend <= restart_pend | i_restart;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            state   <= S_ISSUE;
            cnt     <= '0;
            retries <= retries + RTY_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_NEXT: begin
          if (o_index == 4'd9) begin
            state <= S_DONE;
          end else begin
            o_index <= o_index + 4'd1;
            retries <= '0;
            state   <= S_ISSUE;
          end
        end
        S_DONE:  o_config_ok   <= 1'b1;
        S_FAIL:  o_config_fail <= 1'b1;
        default: state <= S_PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// Randomized bench for hdmi_cfg_sequencer: an I2C master model answers each request
// and the observed write sequence is compared against a table-level reference model.
module tb_hdmi_cfg_sequencer;

  localparam int P  = 10;
  localparam int T  = 20;
  localparam int G  = 6;
  localparam int MR = 3;

  logic       i_clk = 1'b0;
  logic       i_rst_n, i_restart, i_done, i_nack;
  logic       o_req;
  logic [6:0] o_dev_addr;
  logic [7:0] o_reg_addr, o_reg_data;
  logic [3:0] o_index;
  logic       o_config_ok, o_config_fail;

  int checks = 0;
  int errors = 0;

  logic [7:0] tbl_reg [10] = '{8'h41, 8'h98, 8'h9A, 8'h9C, 8'h9D, 8'hA2, 8'hA3, 8'hE0, 8'hF9, 8'h15};
  logic [7:0] tbl_dat [10] = '{8'h10, 8'h03, 8'hE0, 8'h30, 8'h61, 8'hA4, 8'hA4, 8'hD0, 8'h00, 8'h01};

  int          nack_plan [10];
  int          timeout_entry, restart_entry, abort_entry, fixed_delay;
  logic [19:0] exp_q[$];
  logic [19:0] obs_q[$];
  bit          exp_fail;
  int          exp_fail_idx;

  hdmi_cfg_sequencer #(
    .POWERUP_CYCLES(P), .TIMEOUT_CYCLES(T), .RETRY_GAP(G), .MAX_RETRIES(MR), .DEV_ADDR(7'h39)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_restart(i_restart), .i_done(i_done), .i_nack(i_nack),
    .o_req(o_req), .o_dev_addr(o_dev_addr), .o_reg_addr(o_reg_addr), .o_reg_data(o_reg_data),
    .o_index(o_index), .o_config_ok(o_config_ok), .o_config_fail(o_config_fail)
  );

  always #20 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] ent(input int e);
    return {4'(e), tbl_reg[e], tbl_dat[e]};
  endfunction

  task automatic clear_plan();
    foreach (nack_plan[i]) nack_plan[i] = 0;
    timeout_entry = -1;
    restart_entry = -1;
    abort_entry   = -1;
    fixed_delay   = 0;
  endtask

  // Reference: each entry needs (failures + 1) attempts; more than MR retries ends in fail.
  function automatic void build_expected();
    int fails;
    exp_q.delete();
    exp_fail = 0;
    exp_fail_idx = 0;
    if (restart_entry >= 0)
      for (int e = 0; e <= restart_entry; e++) exp_q.push_back(ent(e));
    for (int e = 0; e < 10; e++) begin
      if (e == abort_entry) begin
        exp_q.push_back(ent(e));
        break;
      end
      fails = nack_plan[e] + ((e == timeout_entry) ? 1 : 0);
      if (fails > MR) begin
        repeat (MR + 1) exp_q.push_back(ent(e));
        exp_fail = 1;
        exp_fail_idx = e;
        break;
      end
      repeat (fails + 1) exp_q.push_back(ent(e));
    end
  endfunction

  task automatic pulse_restart();
    i_restart = 1'b1;
    @(negedge i_clk);
    i_restart = 1'b0;
  endtask

  // I2C master model and protocol monitor; called at a negedge.
  task automatic run_seq(input int first_low);
    int att [10];
    int low, hold, idx, exp_low;
    bit fail_now, tmo_now, rs_now, finished, stable;
    logic [7:0] ra, rd;
    exp_low = first_low;
    foreach (att[i]) att[i] = 0;
    obs_q.delete();
    finished = 0;
    while (!finished) begin
      low = 0;
      while (o_req !== 1'b1 && low < 300) begin
        @(negedge i_clk);
        low++;
      end
      checks++;
      if (o_req !== 1'b1) begin
        $display("FAIL req_wait: o_req=%b after %0d cycles, required 1", o_req, low);
        errors++;
        break;
      end
      checks++;
      if (low != exp_low) begin
        $display("FAIL req_gap: o_req rose after %0d cycles, required %0d (index %0d)", low, exp_low, o_index);
        errors++;
      end
      idx = int'(o_index);
      if (idx > 9) idx = 9;
      ra = o_reg_addr;
      rd = o_reg_data;
      obs_q.push_back({o_index, ra, rd});
      tmo_now  = (idx == timeout_entry) && (att[idx] == 0);
      fail_now = tmo_now || (att[idx] < nack_plan[idx]);
      rs_now   = (idx == restart_entry);
      att[idx]++;
      if (idx == abort_entry) begin
        @(negedge i_clk);
        #5 i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_req !== 1'b0 || o_index !== 4'd0 || o_config_ok !== 1'b0 || o_config_fail !== 1'b0 || o_reg_addr !== 8'h41) begin
          $display("FAIL async_reset: req=%b idx=%0d ok=%b fail=%b reg=%h, required 0/0/0/0/41",
                   o_req, o_index, o_config_ok, o_config_fail, o_reg_addr);
          errors++;
        end
        finished = 1;
      end else if (tmo_now) begin
        hold = 0;
        while (o_req === 1'b1 && hold < T + 10) begin
          @(negedge i_clk);
          hold++;
        end
        checks++;
        if (hold != T) begin
          $display("FAIL timeout_len: o_req high %0d cycles, required %0d", hold, T);
          errors++;
        end
        @(negedge i_clk);
        @(negedge i_clk);
        i_done = 1'b1;
        i_nack = 1'b0;
        @(negedge i_clk);
        i_done = 1'b0;
        checks++;
        if (o_req !== 1'b0 || o_index !== 4'(idx)) begin
          $display("FAIL late_done: req=%b idx=%0d, required 0/%0d", o_req, o_index, idx);
          errors++;
        end
        exp_low = G - 2;
      end else begin
        hold = rs_now ? 6 : ((fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 7)));
        stable = 1;
        for (int k = 0; k < hold; k++) begin
          i_restart = rs_now && (k == 1 || k == 3);
          @(negedge i_clk);
          if (o_req !== 1'b1 || o_reg_addr !== ra || o_reg_data !== rd) stable = 0;
        end
        i_restart = 1'b0;
        checks++;
        if (!stable) begin
          $display("FAIL req_hold: request not held stable at index %0d, required stable", idx);
          errors++;
        end
        i_done = 1'b1;
        i_nack = fail_now;
        @(negedge i_clk);
        i_done = 1'b0;
        i_nack = 1'b0;
        checks++;
        if (o_req !== 1'b0) begin
          $display("FAIL req_fall: o_req=%b after i_done, required 0", o_req);
          errors++;
        end
        if (rs_now) begin
          restart_entry = -1;
          foreach (att[i]) att[i] = 0;
          exp_low = 1;
          checks++;
          if (o_config_ok !== 1'b0 || o_config_fail !== 1'b0) begin
            $display("FAIL restart_flags: ok=%b fail=%b, required 0/0", o_config_ok, o_config_fail);
            errors++;
          end
        end else if (fail_now && att[idx] > MR) begin
          checks++;
          if (o_config_fail !== 1'b0) begin
            $display("FAIL fail_early: o_config_fail=%b, required 0", o_config_fail);
            errors++;
          end
          @(negedge i_clk);
          checks++;
          if (o_config_fail !== 1'b1) begin
            $display("FAIL fail_timing: o_config_fail=%b, required 1", o_config_fail);
            errors++;
          end
          repeat (5) @(negedge i_clk);
          checks++;
          if (o_req !== 1'b0 || o_index !== 4'(idx) || o_config_ok !== 1'b0) begin
            $display("FAIL fail_hold: req=%b idx=%0d ok=%b, required 0/%0d/0", o_req, o_index, o_config_ok, idx);
            errors++;
          end
          finished = 1;
        end else if (fail_now) begin
          exp_low = G + 1;
        end else if (idx == 9) begin
          @(negedge i_clk);
          checks++;
          if (o_config_ok !== 1'b0) begin
            $display("FAIL ok_early: o_config_ok=%b, required 0", o_config_ok);
            errors++;
          end
          @(negedge i_clk);
          checks++;
          if (o_config_ok !== 1'b1 || o_config_fail !== 1'b0) begin
            $display("FAIL ok_timing: ok=%b fail=%b, required 1/0", o_config_ok, o_config_fail);
            errors++;
          end
          finished = 1;
        end else begin
          exp_low = 2;
        end
      end
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      $display("FAIL seq_len: %0d requests, required %0d", obs_q.size(), exp_q.size());
      errors++;
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL seq_entry[%0d]: idx/reg/data=%h, required %h", i, obs_q[i], exp_q[i]);
        errors++;
      end
    end
  endtask

  task automatic check_restart_cleared(input string tag);
    checks++;
    if (o_config_ok !== 1'b0 || o_config_fail !== 1'b0 || o_index !== 4'd0) begin
      $display("FAIL %s_clear: ok=%b fail=%b idx=%0d, required 0/0/0", tag, o_config_ok, o_config_fail, o_index);
      errors++;
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b1; i_restart = 1'b0; i_done = 1'b0; i_nack = 1'b0;
    #5 i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++;
    if (o_req !== 1'b0 || o_index !== 4'd0 || o_config_ok !== 1'b0 || o_config_fail !== 1'b0) begin
      $display("FAIL reset_ctrl: req=%b idx=%0d ok=%b fail=%b, required 0/0/0/0", o_req, o_index, o_config_ok, o_config_fail);
      errors++;
    end
    checks++;
    if (o_reg_addr !== 8'h41 || o_reg_data !== 8'h10 || o_dev_addr !== 7'h39) begin
      $display("FAIL reset_data: reg=%h data=%h dev=%h, required 41/10/39", o_reg_addr, o_reg_data, o_dev_addr);
      errors++;
    end
    i_rst_n = 1'b1;
  endtask

  task automatic test_normal_boot();
    clear_plan();
    fixed_delay = 5;
    build_expected();
    run_seq(P + 1);
    checks++;
    if (o_config_ok !== 1'b1 || o_config_fail !== 1'b0) begin
      $display("FAIL boot_flags: ok=%b fail=%b, required 1/0", o_config_ok, o_config_fail);
      errors++;
    end
  endtask

  task automatic test_nack_recovery();
    clear_plan();
    nack_plan[3] = 2;
    build_expected();
    pulse_restart();
    check_restart_cleared("done_restart");
    run_seq(1);
    checks++;
    if (o_config_ok !== 1'b1) begin
      $display("FAIL nack_ok: ok=%b, required 1", o_config_ok);
      errors++;
    end
  endtask

  task automatic test_retry_exhaust();
    clear_plan();
    nack_plan[5] = 99;
    build_expected();
    pulse_restart();
    run_seq(1);
    checks++;
    if (o_config_fail !== 1'b1 || o_config_ok !== 1'b0 || o_index !== 4'd5) begin
      $display("FAIL exhaust_flags: fail=%b ok=%b idx=%0d, required 1/0/5", o_config_fail, o_config_ok, o_index);
      errors++;
    end
  endtask

  task automatic test_timeout();
    clear_plan();
    timeout_entry = 0;
    build_expected();
    pulse_restart();
    check_restart_cleared("fail_restart");
    run_seq(1);
    checks++;
    if (o_config_ok !== 1'b1 || o_config_fail !== 1'b0) begin
      $display("FAIL timeout_flags: ok=%b fail=%b, required 1/0", o_config_ok, o_config_fail);
      errors++;
    end
  endtask

  task automatic test_restart_wait();
    clear_plan();
    restart_entry = 6;
    build_expected();
    pulse_restart();
    run_seq(1);
    checks++;
    if (o_config_ok !== 1'b1 || o_config_fail !== 1'b0) begin
      $display("FAIL restart_wait_flags: ok=%b fail=%b, required 1/0", o_config_ok, o_config_fail);
      errors++;
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      clear_plan();
      foreach (nack_plan[i]) nack_plan[i] = int'($urandom_range(0, 2));
      if (r == 2) nack_plan[$urandom_range(0, 9)] = MR + 1;
      build_expected();
      pulse_restart();
      run_seq(1);
      checks++;
      if (o_config_fail !== exp_fail || o_config_ok !== !exp_fail ||
          (exp_fail && o_index !== 4'(exp_fail_idx))) begin
        $display("FAIL random_flags[%0d]: ok=%b fail=%b idx=%0d, required %b/%b/%0d",
                 r, o_config_ok, o_config_fail, o_index, !exp_fail, exp_fail, exp_fail_idx);
        errors++;
      end
    end
  endtask

  task automatic test_async_reset();
    clear_plan();
    abort_entry = 4;
    build_expected();
    pulse_restart();
    run_seq(1);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    clear_plan();
    build_expected();
    run_seq(P + 1);
    checks++;
    if (o_config_ok !== 1'b1) begin
      $display("FAIL post_reset_ok: ok=%b, required 1", o_config_ok);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_normal_boot();
    test_nack_recovery();
    test_retry_exhaust();
    test_timeout();
    test_restart_wait();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
